// File: rtl/gray_rx_if.sv
// Sample/decode bundle for the Gray-code receiver: the sender drives Valid and
// GrayIn, the receiver returns the decoded value and the tracking status.
interface gray_rx_if;
  logic       Valid;
  logic [2:0] GrayIn;
  logic [2:0] Binary;
  logic       Locked;
  logic       Error;
  logic [3:0] Wraps;
  logic       Overflow;

  modport master (
    output Valid, GrayIn,
    input  Binary, Locked, Error, Wraps, Overflow
  );

  modport slave (
    input  Valid, GrayIn,
    output Binary, Locked, Error, Wraps, Overflow
  );
endinterface

// File: rtl/gray_rx.sv
// 3-bit Gray-code receiver: decodes accepted samples, checks that they only
// ever step forward by one (or repeat), and counts 7->0 wraps.
//
// state | meaning
// IDLE  | waiting for the first accepted code after reset
// TRACK | following a legal sequence, Locked=1
// FAULT | illegal transition seen, frozen until Reset
module gray_rx (
  input  logic         Clk,
  input  logic         Reset,
  gray_rx_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] prev;
  logic [2:0] dec;

  assign dec = {bus.GrayIn[2],
                bus.GrayIn[2] ^ bus.GrayIn[1],
                bus.GrayIn[2] ^ bus.GrayIn[1] ^ bus.GrayIn[0]};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      prev         <= 3'd0;
      bus.Binary   <= 3'd0;
      bus.Locked   <= 1'b0;
      bus.Error    <= 1'b0;
      bus.Wraps    <= 4'd0;
      bus.Overflow <= 1'b0;
    end else if (bus.Valid) begin
      case (state)
        IDLE: begin
          prev       <= dec;
          bus.Binary <= dec;
          bus.Locked <= 1'b1;
          state      <= TRACK;
        end
        TRACK: begin
          if (dec == prev) begin
            // repeated sample: legal, nothing changes
          end else if (dec == prev + 3'd1) begin
            prev       <= dec;
            bus.Binary <= dec;
            if (prev == 3'd7) begin
              bus.Overflow <= 1'b1;
              if (bus.Wraps != 4'hF)
                bus.Wraps <= bus.Wraps + 4'd1;
            end
          end else begin
            state      <= FAULT;
            bus.Locked <= 1'b0;
            bus.Error  <= 1'b1;
          end
        end
        FAULT: begin
        end
        default: begin
          state      <= IDLE;
          bus.Locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/gray_rx.md
GRAY_RX -- requirements
Module: gray_rx

Interface
REQ-001 Clk  input  1  clock; all state updates on the rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset; Clk is the clock.
REQ-003 Valid  input  1  GrayIn is sampled on an edge where Valid=1; Valid=0 means no update.
REQ-004 GrayIn  input  3  3-bit reflected Gray code, sequence 000,001,011,010,110,111,101,100.
REQ-005 Binary  output  3  registered binary decode of the last accepted code.
REQ-006 Locked  output  1  1 while the block is tracking a legal sequence.
REQ-007 Error  output  1  sticky illegal-transition flag.
REQ-008 Wraps  output  4  count of forward wraps from binary 7 to binary 0; saturates at 15.
REQ-009 Overflow  output  1  sticky; set on the first forward wrap.

Function
REQ-010 Decode SHALL be b2=g2, b1=g2^g1, b0=g2^g1^g0.
REQ-011 The FSM SHALL have three states: IDLE, TRACK and FAULT. State is internal; Locked=1 exactly in TRACK.
REQ-012 An internal 3-bit register SHALL hold the previous accepted binary value (prev).
REQ-013 IDLE, Valid=1: any code SHALL be accepted; Binary and prev <= decode; next state TRACK; Wraps and Overflow unchanged.
REQ-014 TRACK, Valid=1, decode == prev: hold all outputs; no error (repeated sample is legal).
REQ-015 TRACK, Valid=1, decode == (prev+1) mod 8: Binary and prev <= decode; stay in TRACK.
REQ-016 Wrap case of REQ-015 (prev=7, decode=0): Wraps <= min(Wraps+1, 15); Overflow <= 1.
REQ-017 TRACK, Valid=1, any other decode (backward step, skip, multi-bit change): next state FAULT; Error <= 1; Binary, prev, Wraps and Overflow hold.
REQ-018 FAULT SHALL persist until Reset; Valid and GrayIn are ignored there.
REQ-019 Valid=0 in any state: state and all outputs hold.
REQ-020 Latency: an accepted code SHALL appear on Binary, Wraps and Overflow at the same edge it is sampled, visible in the following cycle. There is no combinational path from inputs to outputs.
REQ-021 Wraps SHALL remain 15 at saturation; further wraps still keep Overflow=1 and raise no error.
REQ-022 All outputs SHALL be driven directly from registers.

Reset
REQ-023 Reset=1 at an edge: state <= IDLE; Binary, prev, Wraps <= 0; Locked, Error, Overflow <= 0.
REQ-024 Reset SHALL have priority over Valid in every state; the code presented in a reset cycle is discarded.
REQ-025 Outputs are undefined before the first Reset; the bench SHALL apply Reset first.

Verification
REQ-026 Reset, then Valid=1 each cycle with 000,001,011,010,110,111,101,100,000 -> Binary 0,1,...,7,0; Locked=1 from cycle 2; Wraps=1; Overflow=1; Error=0.
REQ-027 Lock on 011, then 011 again, then 010 -> Binary 2,2,3; Error=0.
REQ-028 Lock on 001, then 010 (skip to binary 3) -> Error=1, Locked=0, Binary stays 1; subsequent 011 ignored; Reset clears Error.
REQ-029 Lock on 011, then 001 (backward step) -> Error=1, Locked=0, Binary stays 2.
REQ-030 17 full legal cycles with Valid gaps interleaved -> Wraps=15 (saturated); Overflow=1; outputs hold on every Valid=0 cycle.
REQ-031 Reset asserted with Valid=1 and GrayIn=110 mid-stream -> next cycle Binary=0, Wraps=0, Locked=0, state IDLE; next Valid code 110 locks with Binary=4.
